bp_cfg_loader: RTL and testbench
================================

// Module: bp_cfg_loader
// PURPOSE
//  Boot-time configuration sequencer. Drives the per-core config bus (core id, addr, data)
//  from a shared init table. Per core: a freeze write, then the core's table entries.
//  After every core is loaded, it sends an unfreeze write to each core and then reports done.
//  Sits between the boot/host logic and the cfg bus fabric of a multicore tile array.
// PARAMETERS
//  num_core_p        1   number of cores to configure (>=1)
//  num_entries_p     4   table entries per core (>=1)
//  cfg_core_width_p  8   width of cfg core id field
//  cfg_addr_width_p  16  width of cfg address
//  cfg_data_width_p  32  width of cfg data
//  freeze_addr_p     16'h0001  cfg address of the per-core freeze register
// PORTS
//  clk_i        in   1                      clock
//  reset_i      in   1                      synchronous, active-high reset
//  start_i      in   1                      start pulse; sampled only in IDLE or DONE
//  rom_addr_o   out  safe_clog2(num_core_p*num_entries_p)  table index = core*num_entries_p+entry
//  rom_data_i   in   cfg_addr_width_p+cfg_data_width_p     {addr,data}; combinational, same cycle
//  cfg_v_o      out  1                      cfg write valid
//  cfg_core_o   out  cfg_core_width_p       target core id (zero-extended counter)
//  cfg_addr_o   out  cfg_addr_width_p       cfg address
//  cfg_data_o   out  cfg_data_width_p       cfg data
//  cfg_ready_i  in   1                      fabric accepts write; transfer = cfg_v_o & cfg_ready_i
//  busy_o       out  1                      high in FREEZE/LOAD/UNFREEZE
//  done_o       out  1                      level; high in DONE
// BEHAVIOUR
//  States: IDLE, FREEZE, LOAD, UNFREEZE, DONE. Counters: core_cnt, entry_cnt.
//  Reset: state=IDLE and counters=0.
//   Reset values of all outputs: cfg_v_o=0, busy_o=0, done_o=0, rom_addr_o=0.
//  IDLE/DONE + start_i: go to FREEZE, core_cnt=0, entry_cnt=0; done_o drops the next cycle.
//   First cfg_v_o is one cycle after start_i.
//  FREEZE: cfg_v_o=1, core=core_cnt, addr=freeze_addr_p, data=1.
//   On transfer: go to LOAD with entry_cnt=0.
//  LOAD: cfg_v_o=1, core=core_cnt, {addr,data}=rom_data_i, rom_addr_o=core_cnt*num_entries_p+entry_cnt.
//   On transfer with entry_cnt<num_entries_p-1: entry_cnt++.
//   On the last entry: if core_cnt<num_core_p-1, core_cnt++ and go to FREEZE.
//   Otherwise core_cnt=0 and go to UNFREEZE.
//  UNFREEZE: cfg_v_o=1, core=core_cnt, addr=freeze_addr_p, data=0.
//   On transfer: core_cnt++; after the last core, go to DONE.
//  Handshake rules:
//   - cfg_v_o never drops without a transfer.
//   - core/addr/data are held stable while cfg_v_o & ~cfg_ready_i.
//   - rom_addr_o is held too, so rom_data_i must be stable for a stable index.
//  Throughput: one write per cycle with ready held high.
//   Total writes = num_core_p*(num_entries_p+2).
//  done_o rises the cycle after the final UNFREEZE transfer.
//  start_i while busy_o=1 is ignored (no restart, no queuing).
//  Counters never wrap; rom_addr_o max = num_core_p*num_entries_p-1.
//  cfg_core_o is upper-zero-extended; require num_core_p <= 2**cfg_core_width_p (assert).
//  Reset mid-sequence: next cycle is IDLE with cfg_v_o=0; a partially accepted sequence is abandoned.
//  Outside FREEZE/LOAD/UNFREEZE, cfg_core_o/addr/data are don't-care but must be X-free (drive 0).
// TESTING
//  1. N=2,E=2, ready=1, start at cycle 0.
//     -> cfg_v_o high cycles 1-8; core/addr/data sequence:
//     F0,T0,T1,F1,T2,T3,U0,U1; done_o=1 at cycle 9.
//  2. Same config, ready toggling 1,0,1,0.
//     -> payload identical to test 1; every stall cycle holds outputs; done_o after 16 cycles.
//  3. Pulse start_i at cycle 4 during a busy run.
//     -> sequence unchanged, 8 writes; a start in DONE reruns the full sequence.
//  4. reset_i at cycle 5 (in LOAD, core 1).
//     -> cycle 6: cfg_v_o=0, busy_o=0, done_o=0. A new start replays from core 0 freeze.
//  5. N=1,E=1, ready=1.
//     -> exactly 3 writes (freeze, T0 via rom_addr_o=0, unfreeze); done_o at cycle 4.
//  6. Hold ready=0 for 20 cycles in UNFREEZE.
//     -> cfg_v_o stays 1, data=0, core stable; done_o stays 0 until acceptance.

Source files
------------

// File: rtl/bp_cfg_loader.sv
// Boot-time configuration sequencer: freezes each core, streams its init-table entries onto
// the cfg bus, then unfreezes every core and reports done.
module bp_cfg_loader #(
  parameter int num_core_p       = 1,
  parameter int num_entries_p    = 4,
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter logic [cfg_addr_width_p-1:0] freeze_addr_p = 'h0001,
  localparam int rom_addr_width_lp = (num_core_p * num_entries_p > 1)
                                   ? $clog2(num_core_p * num_entries_p) : 1
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic                                       start_i,
  output logic [rom_addr_width_lp-1:0]               rom_addr_o,
  input  logic [cfg_addr_width_p+cfg_data_width_p-1:0] rom_data_i,
  output logic                                       cfg_v_o,
  output logic [cfg_core_width_p-1:0]                cfg_core_o,
  output logic [cfg_addr_width_p-1:0]                cfg_addr_o,
  output logic [cfg_data_width_p-1:0]                cfg_data_o,
  input  logic                                       cfg_ready_i,
  output logic                                       busy_o,
  output logic                                       done_o
);

  localparam int ccw_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
  localparam int ecw_lp = (num_entries_p > 1) ? $clog2(num_entries_p) : 1;
  localparam logic [ccw_lp-1:0] last_core_lp  = ccw_lp'(num_core_p - 1);
  localparam logic [ecw_lp-1:0] last_entry_lp = ecw_lp'(num_entries_p - 1);
  localparam logic [ccw_lp-1:0] core_one_lp   = ccw_lp'(1);
  localparam logic [ecw_lp-1:0] entry_one_lp  = ecw_lp'(1);
  localparam bit core_id_fits_lp = (64'(num_core_p) <= (64'd1 << cfg_core_width_p));

  typedef enum logic [2:0] {IDLE, FREEZE, LOAD, UNFREEZE, DONE} state_e;

  state_e                        state_r, state_n;
  logic [ccw_lp-1:0]             core_cnt_r, core_cnt_n;
  logic [ecw_lp-1:0]             entry_cnt_r, entry_cnt_n;
  logic                          cfg_v_r;
  logic                          done_r;
  logic [rom_addr_width_lp-1:0]  rom_addr_r;
  logic [cfg_core_width_p-1:0]   core_r;
  logic                          freeze_set_r;
  logic                          xfer;

  function automatic logic [rom_addr_width_lp-1:0] rom_index(
    input logic [ccw_lp-1:0] core,
    input logic [ecw_lp-1:0] entry
  );
    return rom_addr_width_lp'(core) * rom_addr_width_lp'(num_entries_p)
         + rom_addr_width_lp'(entry);
  endfunction

  function automatic logic is_active(input state_e s);
    return (s == FREEZE) || (s == LOAD) || (s == UNFREEZE);
  endfunction

  assign xfer = cfg_v_r & cfg_ready_i;

  // Next-state logic; nothing advances without a bus transfer, which keeps stalls stable.
  always_comb begin
    state_n     = state_r;
    core_cnt_n  = core_cnt_r;
    entry_cnt_n = entry_cnt_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          state_n     = FREEZE;
          core_cnt_n  = '0;
          entry_cnt_n = '0;
        end
      end
      FREEZE: begin
        if (xfer) begin
          state_n     = LOAD;
          entry_cnt_n = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (entry_cnt_r != last_entry_lp) begin
            entry_cnt_n = entry_cnt_r + entry_one_lp;
          end else if (core_cnt_r != last_core_lp) begin
            core_cnt_n  = core_cnt_r + core_one_lp;
            entry_cnt_n = '0;
            state_n     = FREEZE;
          end else begin
            core_cnt_n  = '0;
            entry_cnt_n = '0;
            state_n     = UNFREEZE;
          end
        end
      end
      UNFREEZE: begin
        if (xfer) begin
          if (core_cnt_r != last_core_lp) begin
            core_cnt_n = core_cnt_r + core_one_lp;
          end else begin
            core_cnt_n = '0;
            state_n    = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control registers: outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      core_cnt_r  <= '0;
      entry_cnt_r <= '0;
      cfg_v_r     <= 1'b0;
      done_r      <= 1'b0;
      rom_addr_r  <= '0;
    end else begin
      state_r     <= state_n;
      core_cnt_r  <= core_cnt_n;
      entry_cnt_r <= entry_cnt_n;
      cfg_v_r     <= is_active(state_n);
      done_r      <= (state_n == DONE);
      rom_addr_r  <= (state_n == LOAD) ? rom_index(core_cnt_n, entry_cnt_n) : '0;
    end
  end

  // Payload registers carry no reset; the output gating below keeps the bus X-free when idle.
  always_ff @(posedge clk_i) begin
    core_r       <= cfg_core_width_p'(core_cnt_n);
    freeze_set_r <= (state_n == FREEZE);
  end

  assign cfg_v_o    = cfg_v_r;
  assign busy_o     = cfg_v_r;
  assign done_o     = done_r;
  assign rom_addr_o = rom_addr_r;
  assign cfg_core_o = cfg_v_r ? core_r : '0;

  always_comb begin
    cfg_addr_o = '0;
    cfg_data_o = '0;
    if (cfg_v_r && (state_r == LOAD)) begin
      {cfg_addr_o, cfg_data_o} = rom_data_i;
    end else if (cfg_v_r) begin
      cfg_addr_o = freeze_addr_p;
      cfg_data_o = cfg_data_width_p'(freeze_set_r);
    end
  end

  // The core id is zero-extended, so every core index must fit in the id field.
  assert property (@(posedge clk_i) core_id_fits_lp);

  assert property (@(posedge clk_i) disable iff (reset_i)
    (cfg_v_o && !cfg_ready_i) |=> (cfg_v_o && $stable(cfg_core_o) && $stable(cfg_addr_o)
                                   && $stable(cfg_data_o) && $stable(rom_addr_o)));

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Bench for bp_cfg_loader: table-driven cycle vectors, hand sequences for stalls/reset, and
// randomized runs scored against a write-list model built from the init table.
module tb_bp_cfg_loader;

  localparam int NA = 2;
  localparam int EA = 2;
  localparam logic [47:0] ROM_B = 48'h5A5A_1234_5678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic        start_a, ready_a, start_b, ready_b;
  logic [1:0]  rom_addr_a;
  logic [47:0] rom_data_a;
  logic        cfg_v_a, busy_a, done_a;
  logic [7:0]  core_a;
  logic [15:0] addr_a;
  logic [31:0] data_a;
  logic [0:0]  rom_addr_b;
  logic [47:0] rom_data_b;
  logic        cfg_v_b, busy_b, done_b;
  logic [7:0]  core_b;
  logic [15:0] addr_b;
  logic [31:0] data_b;

  logic [47:0] rom_a [NA*EA];
  assign rom_data_a = rom_a[rom_addr_a];
  assign rom_data_b = (rom_addr_b == 1'b0) ? ROM_B : 48'hFFFF_FFFF_FFFF;

  bp_cfg_loader #(.num_core_p(NA), .num_entries_p(EA)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_a),
    .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
    .cfg_v_o(cfg_v_a), .cfg_core_o(core_a), .cfg_addr_o(addr_a), .cfg_data_o(data_a),
    .cfg_ready_i(ready_a), .busy_o(busy_a), .done_o(done_a)
  );

  bp_cfg_loader #(.num_core_p(1), .num_entries_p(1)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_b),
    .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b),
    .cfg_v_o(cfg_v_b), .cfg_core_o(core_b), .cfg_addr_o(addr_b), .cfg_data_o(data_b),
    .cfg_ready_i(ready_b), .busy_o(busy_b), .done_o(done_b)
  );

  typedef struct {
    logic        start, ready, v, done;
    logic [7:0]  core;
    logic [15:0] addr;
    logic [31:0] data;
    logic [1:0]  ra;
  } vec_t;

  typedef vec_t vec10_t [10];

  typedef struct {
    logic [7:0]  core;
    logic [15:0] addr;
    logic [31:0] data;
    int          kind;
    int          idx;
  } exp_t;

  int checks = 0;
  int failures = 0;
  vec10_t t1, t3;
  vec_t   t5 [5];
  int     dc;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic rd, input logic v, input logic dn,
                              input logic [7:0] core, input logic [15:0] addr,
                              input logic [31:0] data, input logic [1:0] ra);
    vec_t r;
    r.start = st; r.ready = rd; r.v = v; r.done = dn;
    r.core = core; r.addr = addr; r.data = data; r.ra = ra;
    return r;
  endfunction

  function automatic logic [47:0] fixed_rom(input int i);
    return {16'h1000 + 16'(i), 32'hCAFE_0000 + 32'(i)};
  endfunction

  // Applies rows of a cycle table to dut_a; rst_row (if >=0) raises reset on that row.
  task automatic apply(input vec10_t tv, input int n, input int rst_row, input string tag);
    for (int i = 0; i < n; i++) begin
      start_a = tv[i].start;
      ready_a = tv[i].ready;
      reset_i = (i == rst_row);
      chk($sformatf("%s[%0d] ctl", tag, i), 64'({cfg_v_a, busy_a, done_a}),
          64'({tv[i].v, tv[i].v, tv[i].done}));
      chk($sformatf("%s[%0d] payload", tag, i), 64'({core_a, addr_a, data_a}),
          64'({tv[i].core, tv[i].addr, tv[i].data}));
      if (tv[i].v && tv[i].addr != 16'h0001)
        chk($sformatf("%s[%0d] rom_addr", tag, i), 64'(rom_addr_a), 64'(tv[i].ra));
      cyc();
    end
    start_a = 1'b0;
  endtask

  // Full run on dut_a scored against the expected write list.
  // mode 0: ready=1, 1: ready on odd cycles, 2: random ready, 3: random ready+starts,
  // 4: ready=1 except 20 stall cycles on the first unfreeze write.
  task automatic run_a(input int mode, input string tag, output int dcyc);
    exp_t q[$];
    exp_t e;
    int   c, stall;
    bit   done_seen;
    logic rdy;
    for (int k = 0; k < NA; k++) begin
      e.core = 8'(k); e.addr = 16'h0001; e.data = 32'd1; e.kind = 0; e.idx = -1;
      q.push_back(e);
      for (int j = 0; j < EA; j++) begin
        e.idx = k * EA + j; e.kind = 1;
        e.addr = rom_a[e.idx][47:32];
        e.data = rom_a[e.idx][31:0];
        q.push_back(e);
      end
    end
    for (int k = 0; k < NA; k++) begin
      e.core = 8'(k); e.addr = 16'h0001; e.data = 32'd0; e.kind = 2; e.idx = -1;
      q.push_back(e);
    end
    start_a = 1'b1;
    ready_a = 1'b1;
    c = 0; stall = 0; done_seen = 1'b0; dcyc = -1;
    while (!done_seen && c < 400) begin
      cyc();
      c++;
      if (q.size() == 0) begin
        chk($sformatf("%s done c%0d", tag, c), 64'({cfg_v_a, busy_a, done_a}), 64'(3'b001));
        done_seen = 1'b1;
        dcyc = c;
        start_a = 1'b0;
      end else begin
        chk($sformatf("%s ctl c%0d", tag, c), 64'({cfg_v_a, busy_a, done_a}), 64'(3'b110));
        chk($sformatf("%s payload c%0d", tag, c), 64'({core_a, addr_a, data_a}),
            64'({q[0].core, q[0].addr, q[0].data}));
        if (q[0].kind == 1)
          chk($sformatf("%s rom_addr c%0d", tag, c), 64'(rom_addr_a), 64'(q[0].idx));
        case (mode)
          0: rdy = 1'b1;
          1: rdy = (c % 2 == 1);
          2, 3: rdy = ($urandom_range(0, 3) != 0);
          4: begin
            if (q[0].kind == 2 && stall < 20) begin
              rdy = 1'b0;
              stall++;
            end else begin
              rdy = 1'b1;
            end
          end
          default: rdy = 1'b1;
        endcase
        ready_a = rdy;
        start_a = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (rdy) void'(q.pop_front());
      end
    end
    if (!done_seen) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: %0d writes still pending after %0d cycles", tag, q.size(), c);
    end
    ready_a = 1'b1;
  endtask

  initial begin
    reset_i = 1'b1;
    start_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b0; ready_b = 1'b1;
    for (int i = 0; i < NA * EA; i++) rom_a[i] = fixed_rom(i);

    t1[0] = mk(1, 1, 0, 0, 8'd0, 16'h0000, 32'h0, 2'd0);
    t1[1] = mk(0, 1, 1, 0, 8'd0, 16'h0001, 32'h1, 2'd0);
    t1[2] = mk(0, 1, 1, 0, 8'd0, 16'h1000, 32'hCAFE_0000, 2'd0);
    t1[3] = mk(0, 1, 1, 0, 8'd0, 16'h1001, 32'hCAFE_0001, 2'd1);
    t1[4] = mk(0, 1, 1, 0, 8'd1, 16'h0001, 32'h1, 2'd0);
    t1[5] = mk(0, 1, 1, 0, 8'd1, 16'h1002, 32'hCAFE_0002, 2'd2);
    t1[6] = mk(0, 1, 1, 0, 8'd1, 16'h1003, 32'hCAFE_0003, 2'd3);
    t1[7] = mk(0, 1, 1, 0, 8'd0, 16'h0001, 32'h0, 2'd0);
    t1[8] = mk(0, 1, 1, 0, 8'd1, 16'h0001, 32'h0, 2'd0);
    t1[9] = mk(0, 1, 0, 1, 8'd0, 16'h0000, 32'h0, 2'd0);
    t3 = t1;
    t3[0].done  = 1'b1;
    t3[4].start = 1'b1;

    t5[0] = mk(1, 1, 0, 0, 8'd0, 16'h0000, 32'h0, 2'd0);
    t5[1] = mk(0, 1, 1, 0, 8'd0, 16'h0001, 32'h1, 2'd0);
    t5[2] = mk(0, 1, 1, 0, 8'd0, 16'h5A5A, 32'h1234_5678, 2'd0);
    t5[3] = mk(0, 1, 1, 0, 8'd0, 16'h0001, 32'h0, 2'd0);
    t5[4] = mk(0, 1, 0, 1, 8'd0, 16'h0000, 32'h0, 2'd0);

    repeat (3) cyc();
    reset_i = 1'b0;

    chk("reset ctl a", 64'({cfg_v_a, busy_a, done_a, rom_addr_a}), 64'd0);
    chk("reset payload a", 64'({core_a, addr_a, data_a}), 64'd0);
    chk("reset ctl b", 64'({cfg_v_b, busy_b, done_b, rom_addr_b}), 64'd0);

    apply(t1, 10, -1, "t1");
    apply(t3, 10, -1, "t3");

    run_a(1, "t2", dc);
    chk("t2 done cycle", 64'(dc), 64'd16);

    apply(t3, 6, 5, "t4");
    chk("t4 after reset ctl", 64'({cfg_v_a, busy_a, done_a}), 64'd0);
    chk("t4 after reset rom_addr", 64'(rom_addr_a), 64'd0);
    reset_i = 1'b0;
    run_a(0, "t4 replay", dc);
    chk("t4 replay done cycle", 64'(dc), 64'd9);

    run_a(4, "t6", dc);
    chk("t6 done cycle", 64'(dc), 64'd29);

    for (int i = 0; i < 5; i++) begin
      start_b = t5[i].start;
      ready_b = t5[i].ready;
      chk($sformatf("t5[%0d] ctl", i), 64'({cfg_v_b, busy_b, done_b}),
          64'({t5[i].v, t5[i].v, t5[i].done}));
      chk($sformatf("t5[%0d] payload", i), 64'({core_b, addr_b, data_b}),
          64'({t5[i].core, t5[i].addr, t5[i].data}));
      if (i == 2) chk("t5 rom_addr", 64'(rom_addr_b), 64'd0);
      cyc();
    end
    start_b = 1'b0;

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NA * EA; i++) rom_a[i] = {16'($urandom), 32'($urandom)};
      run_a((r % 2 == 0) ? 2 : 3, $sformatf("rnd%0d", r), dc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
